// File: rtl/mem_arbiter_if.sv
// Requester/memory bus bundle for mem_arbiter: CPU and DMA handshake sets,
// shared read-data/busy returns, and the single memory port.
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_ack;

  logic             dma_req;
  logic             dma_we;
  logic [WIDTH-1:0] dma_addr;
  logic [WIDTH-1:0] dma_wdata;
  logic             dma_ack;

  logic [WIDTH-1:0] rdata;
  logic             busy;

  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, dma_ack, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester/memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, dma_ack, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the CPU
// (requester 0) and the DMA/display engine (requester 1).
module mem_arbiter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

  state_t           state;
  logic             owner;
  logic             last;
  logic             we_q;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             grant_dma;

  // On a tie the requester not granted last time wins
  always_comb begin
    grant_dma = 1'b0;
    if (bus.cpu_req && bus.dma_req) grant_dma = ~last;
    else                            grant_dma = bus.dma_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      we_q    <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            owner   <= grant_dma;
            we_q    <= grant_dma ? bus.dma_we    : bus.cpu_we;
            addr_q  <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
            wdata_q <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= CNT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!we_q) rdata_q <= bus.mem_rdata;
            state <= ACK;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ACK: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state so reset removes them without waiting for a clock
  assign bus.busy      = (state != IDLE);
  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.cpu_ack   = (state == ACK) && !owner;
  assign bus.dma_ack   = (state == ACK) &&  owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1, one at 3,
// each fed by a small latency-accurate memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;
  int n_fail;

  mem_arbiter_if #(.WIDTH(16)) b1 ();
  mem_arbiter_if #(.WIDTH(16)) b3 ();

  mem_arbiter #(.WIDTH(16), .MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.WIDTH(16), .MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  // Memory model: data valid only in the cycle it is due, garbage otherwise
  int unsigned m1_left, m3_left;
  logic [15:0] m1_data, m3_data;

  always @(posedge clk or posedge rst) begin
    if (rst) m1_left <= 0;
    else if (b1.mem_en && !b1.mem_we) begin
      m1_left <= 1;
      m1_data <= mem_fn(b1.mem_addr);
    end else if (m1_left != 0) m1_left <= m1_left - 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m3_left <= 0;
    else if (b3.mem_en && !b3.mem_we) begin
      m3_left <= 3;
      m3_data <= mem_fn(b3.mem_addr);
    end else if (m3_left != 0) m3_left <= m3_left - 1;
  end

  assign b1.mem_rdata = (m1_left == 1) ? m1_data : 16'hDEAD;
  assign b3.mem_rdata = (m3_left == 1) ? m3_data : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    rst = 1'b1;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = '0; b1.dma_wdata = '0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.dma_req = 0; b3.dma_we = 0; b3.dma_addr = '0; b3.dma_wdata = '0;
    tick();
    tick();

    // Reset values
    chk("rst_busy",    b1.busy,      0);
    chk("rst_mem_en",  b1.mem_en,    0);
    chk("rst_mem_we",  b1.mem_we,    0);
    chk("rst_addr",    b1.mem_addr,  16'h0000);
    chk("rst_wdata",   b1.mem_wdata, 16'h0000);
    chk("rst_rdata",   b1.rdata,     16'h0000);
    chk("rst_cpu_ack", b1.cpu_ack,   0);
    chk("rst_dma_ack", b1.dma_ack,   0);
    chk("rst3_busy",   b3.busy,      0);
    rst = 1'b0;
    tick();
    chk("idle_busy", b1.busy, 0);

    // Single CPU read of 0x0040
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0040; b1.cpu_wdata = 16'h7777;
    tick();
    chk("t1_en",      b1.mem_en,   1);
    chk("t1_addr",    b1.mem_addr, 16'h0040);
    chk("t1_we",      b1.mem_we,   0);
    chk("t1_busy",    b1.busy,     1);
    chk("t1_dma_ack", b1.dma_ack,  0);
    tick();
    chk("t1_en_off",  b1.mem_en,   0);
    chk("t1_ack_early", b1.cpu_ack, 0);
    chk("t1_dma_ack", b1.dma_ack,  0);
    tick();
    chk("t1_ack",     b1.cpu_ack,  1);
    chk("t1_rdata",   b1.rdata,    16'hBEEF);
    chk("t1_dma_ack", b1.dma_ack,  0);
    b1.cpu_req = 0;
    tick();
    chk("t1_ack_off", b1.cpu_ack,  0);
    chk("t1_idle",    b1.busy,     0);

    // DMA write 0x1234 to 0x8000
    b1.dma_req = 1; b1.dma_we = 1; b1.dma_addr = 16'h8000; b1.dma_wdata = 16'h1234;
    tick();
    chk("t2_en",    b1.mem_en,    1);
    chk("t2_we",    b1.mem_we,    1);
    chk("t2_addr",  b1.mem_addr,  16'h8000);
    chk("t2_wdata", b1.mem_wdata, 16'h1234);
    tick();
    chk("t2_en_off", b1.mem_en,   0);
    chk("t2_we_off", b1.mem_we,   0);
    chk("t2_hold",   b1.mem_addr, 16'h8000);
    tick();
    chk("t2_ack",     b1.dma_ack, 1);
    chk("t2_cpu_ack", b1.cpu_ack, 0);
    chk("t2_rdata",   b1.rdata,   16'hBEEF);
    b1.dma_req = 0; b1.dma_we = 0;
    tick();
    chk("t2_ack_off", b1.dma_ack, 0);

    // Both requesters held from reset: strict alternation, 4 cycles apart
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b1.cpu_addr = 16'h0010; b1.cpu_we = 0;
    b1.dma_addr = 16'h0020; b1.dma_we = 0;
    b1.cpu_req = 1; b1.dma_req = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("rr_cpu_ack", b1.cpu_ack, (k == 2 || k == 10));
      chk("rr_dma_ack", b1.dma_ack, (k == 6 || k == 14));
      if (k == 0 || k == 8)  chk("rr_cpu_addr", b1.mem_addr, 16'h0010);
      if (k == 4 || k == 12) chk("rr_dma_addr", b1.mem_addr, 16'h0020);
      if (k == 2 || k == 10) chk("rr_cpu_rdata", b1.rdata, 16'hA5B5);
      if (k == 6 || k == 14) chk("rr_dma_rdata", b1.rdata, 16'hA585);
      if (k == 14) begin
        b1.cpu_req = 0;
        b1.dma_req = 0;
      end
    end

    // MEM_LATENCY=3 CPU read; address change during WAIT is ignored
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 16'h0100;
    tick();
    chk("l3_en",   b3.mem_en,   1);
    chk("l3_addr", b3.mem_addr, 16'h0100);
    b3.cpu_addr = 16'h0200;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("l3_ack",    b3.cpu_ack,  (k == 4));
      chk("l3_en_off", b3.mem_en,   0);
      chk("l3_hold",   b3.mem_addr, 16'h0100);
      if (k == 4) chk("l3_rdata", b3.rdata, 16'hA4A5);
    end
    b3.cpu_req = 0;
    tick();
    chk("l3_ack_off", b3.cpu_ack, 0);

    // Reset mid-access: b1 in WAIT, b3 in a write ACCESS cycle
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0040;
    tick();
    b3.dma_req = 1; b3.dma_we = 1; b3.dma_addr = 16'h3000; b3.dma_wdata = 16'h5555;
    tick();
    chk("mr_wait_en", b1.mem_en, 0);
    chk("mr_busy",    b1.busy,   1);
    chk("mr3_we",     b3.mem_we, 1);
    rst = 1'b1;
    #1;
    chk("mr_busy0",   b1.busy,     0);
    chk("mr_addr0",   b1.mem_addr, 16'h0000);
    chk("mr_rdata0",  b1.rdata,    16'h0000);
    chk("mr_ack0",    b1.cpu_ack,  0);
    chk("mr3_we0",    b3.mem_we,   0);
    chk("mr3_en0",    b3.mem_en,   0);
    chk("mr3_wdata0", b3.mem_wdata, 16'h0000);
    b3.dma_req = 0; b3.dma_we = 0;
    tick();
    chk("mr_no_ack", b1.cpu_ack, 0);
    chk("mr_no_en",  b1.mem_en,  0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_post_en",  b1.mem_en,  (k == 0));
      chk("mr_post_ack", b1.cpu_ack, (k == 2));
      if (k == 2) begin
        chk("mr_post_rdata", b1.rdata, 16'hBEEF);
        b1.cpu_req = 0;
      end
    end
    tick();
    chk("mr_post_ack_off", b1.cpu_ack, 0);

    // CPU drops request during ACCESS: single ack, no follow-on access
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0123;
    tick();
    chk("dr_en", b1.mem_en, 1);
    b1.cpu_req = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("dr_ack", b1.cpu_ack, (k == 2));
      chk("dr_en_off", b1.mem_en, 0);
      if (k == 2) chk("dr_rdata", b1.rdata, 16'hA486);
    end
    chk("dr_idle", b1.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single tiny16 memory port between the CPU controller (requester 0) and a DMA/display engine (requester 1). It serialises accesses with a request/acknowledge handshake, applies round-robin priority on simultaneous requests, and sequences the memory's fixed read latency. It sits between the requesters and the memory, replacing the direct `mem_addr_en`/`mem_in_en`/`mem_out_en` strobing of memory.

## Interface
- `WIDTH`, 16: address and data width.
- `MEM_LATENCY`, 1: cycles from memory enable to valid `mem_rdata`; legal range 1..7.

- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cpu_req` input 1: CPU access request; held high until `cpu_ack`.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_addr` input WIDTH: CPU address.
- `cpu_wdata` input WIDTH: CPU write data.
- `cpu_ack` output 1: one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`: same as CPU set, requester 1.
- `rdata` output WIDTH: read data for the acknowledged requester; valid while its ack is high.
- `busy` output 1: high in any state other than IDLE.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: memory write strobe.
- `mem_addr` output WIDTH: memory address.
- `mem_wdata` output WIDTH: memory write data.
- `mem_rdata` input WIDTH: memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE: if neither req high, stay. If exactly one high, it wins. If both high, winner is the requester not granted last (`last` register). On the edge: latch winner's addr/wdata/we into internal registers, `owner` <= winner, go ACCESS.
- ACCESS (1 cycle): `mem_en`=1, `mem_addr`=latched addr, `mem_we`=latched we, `mem_wdata`=latched wdata. Load counter with MEM_LATENCY-1, go WAIT.
- WAIT: `mem_en`=0, `mem_addr` holds latched addr. When counter is 0: on reads capture `mem_rdata` into `rdata`, go ACK; else decrement.
- ACK (1 cycle): assert `owner`'s ack; `last` <= owner; go IDLE.
- Writes take the same path and latency as reads; `rdata` is not updated on writes (holds prior value).
- Request inputs are sampled only in IDLE; changes to addr/wdata/we after the grant edge have no effect on the access in flight.
- A requester dropping req mid-access: access still completes, ack still pulses.
- Req still high in the IDLE cycle after ack is a new request.
- Outputs registered or decoded from state only; no combinational path from req to mem_* or ack.

## Timing
- Reset values: state IDLE, `last`=1 (CPU wins first tie), counter 0, `cpu_ack`=0, `dma_ack`=0, `busy`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0.
- Req sampled high at IDLE edge E0: `mem_en` high in cycle E0+1; `mem_rdata` sampled at edge E0+1+MEM_LATENCY; ack high in cycle E0+2+MEM_LATENCY.
- Minimum spacing between grants: MEM_LATENCY+3 cycles (one mandatory IDLE cycle).
- Both reqs held continuously: grants strictly alternate CPU, DMA, CPU, ...
- `mem_en` and `mem_we` each high for exactly one cycle per access.
- Reset asserted mid-access: immediately return to reset values; in-flight access dropped, no ack issued; `mem_we` must drop asynchronously.

## Test plan
- Single CPU read, MEM_LATENCY=1, memory returns 16'hBEEF at 16'h0040: `cpu_req` at edge 0 -> `mem_en` cycle 1 addr 16'h0040, `cpu_ack`=1 and `rdata`=16'hBEEF in cycle 3, `dma_ack` never high.
- DMA write 16'h1234 to 16'h8000: `mem_en`=`mem_we`=1 for exactly one cycle with that addr/data, `dma_ack` pulse at cycle 3, `rdata` unchanged.
- Both req high from reset and held: order of acks CPU, DMA, CPU, DMA; acks 4 cycles apart (MEM_LATENCY=1).
- MEM_LATENCY=3, CPU read: ack in cycle 5 after sample edge; change `cpu_addr` during WAIT -> `mem_addr` unchanged.
- Assert `rst` during WAIT: all outputs 0 same cycle, no ack; next CPU req completes normally with full latency.
- CPU drops `cpu_req` in ACCESS: `cpu_ack` still pulses once; no second access follows.
